pwm_duty_meter: RTL and testbench

PWM_DUTY_METER -- requirements
Module: pwm_duty_meter

---
 rtl/pwm_duty_meter.sv | 267 ++++++++++++++++++++++++++
 tb/tb_pwm_duty_meter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_duty_meter.sv
// pwm_duty_meter
// Measures the duty cycle of CHANNELS asynchronous comparator inputs over a
// fixed frame of (MAX_VAL+1) sample ticks. Each frame's per-channel result
// is latched into a shadow register. A small delivery FSM then offers the
// results one channel at a time on a valid/ready port. An optional
// hysteresis deadband suppresses results that barely moved since the last
// value delivered for that channel.

module pwm_duty_meter #(
  parameter  int CHANNELS = 2,
  parameter  int WIDTH    = 7,
  parameter  int MAX_VAL  = 99,
  parameter  int PRESCALE = 20,
  parameter  int HYST     = 0,
  localparam int CHW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] comp,
  output logic [WIDTH-1:0]    out_data,
  output logic [CHW-1:0]      out_ch,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                frame_done,
  output logic                overrun,
  input  logic                clear_overrun
);

  // Counter widths; a degenerate count range still gets one bit.
  localparam int PSW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int FW  = (MAX_VAL > 0) ? $clog2(MAX_VAL + 1) : 1;

  localparam logic [PSW-1:0]   PRESC_LAST = PSW'(PRESCALE - 1);
  localparam logic [FW-1:0]    FRAME_LAST = FW'(MAX_VAL);
  localparam logic [WIDTH-1:0] MAX_W      = WIDTH'(MAX_VAL);
  localparam logic [WIDTH:0]   MAX_EXT    = (WIDTH + 1)'(MAX_VAL);
  localparam logic [31:0]      HYST_U     = 32'(HYST);
  localparam logic [CHW-1:0]   IDX_LAST   = CHW'(CHANNELS - 1);

  // Parameter sanity: full scale must fit in the result width.
  if (MAX_VAL >= (1 << WIDTH)) begin : g_bad_max_val
    $error("pwm_duty_meter: MAX_VAL must be smaller than 2**WIDTH");
  end
  if (PRESCALE < 1) begin : g_bad_prescale
    $error("pwm_duty_meter: PRESCALE must be at least 1");
  end
  if (CHANNELS < 1) begin : g_bad_channels
    $error("pwm_duty_meter: CHANNELS must be at least 1");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_OFFER = 2'd2
  } state_t;

  // Result of one frame: high samples plus the final sample, clipped to
  // full scale (all samples high gives MAX_VAL+1 before clipping).
  function automatic logic [WIDTH-1:0] sat_add(input logic [WIDTH-1:0] cnt,
                                               input logic             inc);
    logic [WIDTH:0] sum;
    sum = (WIDTH + 1)'(cnt) + (WIDTH + 1)'(inc);
    if (sum > MAX_EXT) begin
      sat_add = MAX_W;
    end else begin
      sat_add = sum[WIDTH-1:0];
    end
  endfunction

  // Unsigned distance between two results, never wrapping.
  function automatic logic [WIDTH-1:0] abs_diff(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    if (a >= b) begin
      abs_diff = a - b;
    end else begin
      abs_diff = b - a;
    end
  endfunction

  // Input synchronizer
  logic [CHANNELS-1:0] sync1_q, sync1_d;
  logic [CHANNELS-1:0] sync2_q, sync2_d;

  // Measurement datapath
  logic [PSW-1:0]                 presc_q, presc_d;
  logic [FW-1:0]                  frame_q, frame_d;
  logic [CHANNELS-1:0][WIDTH-1:0] high_q, high_d;
  logic [CHANNELS-1:0][WIDTH-1:0] shadow_q, shadow_d;
  logic                           frame_done_q, frame_done_d;
  logic                           tick_s;
  logic                           final_tick_s;

  // Delivery FSM
  state_t                         state_q, state_d;
  logic [CHW-1:0]                 idx_q, idx_d;
  logic [CHANNELS-1:0][WIDTH-1:0] last_q, last_d;
  logic                           first_q, first_d;
  logic                           out_valid_q, out_valid_d;
  logic [WIDTH-1:0]               out_data_q, out_data_d;
  logic [CHW-1:0]                 out_ch_q, out_ch_d;
  logic                           overrun_q, overrun_d;
  logic                           last_idx_s;
  logic                           needed_s;
  logic [WIDTH-1:0]               dist_s;

  assign tick_s       = (presc_q == PRESC_LAST);
  assign final_tick_s = tick_s && (frame_q == FRAME_LAST);
  assign last_idx_s   = (idx_q == IDX_LAST);

  // Two-stage synchronizer; only sync2 feeds the measurement.
  always_comb begin
    sync1_d = comp;
    sync2_d = sync1_q;
  end

  // Prescaler, frame counter, per-channel high counts and shadow capture.
  always_comb begin
    presc_d      = presc_q;
    frame_d      = frame_q;
    high_d       = high_q;
    shadow_d     = shadow_q;
    frame_done_d = 1'b0;
    if (tick_s) begin
      presc_d = {PSW{1'b0}};
      if (final_tick_s) begin
        frame_d      = {FW{1'b0}};
        frame_done_d = 1'b1;
        for (int i = 0; i < CHANNELS; i++) begin
          shadow_d[i] = sat_add(high_q[i], sync2_q[i]);
          high_d[i]   = {WIDTH{1'b0}};
        end
      end else begin
        frame_d = frame_q + FW'(1);
        for (int i = 0; i < CHANNELS; i++) begin
          high_d[i] = high_q[i] + WIDTH'(sync2_q[i]);
        end
      end
    end else begin
      presc_d = presc_q + PSW'(1);
    end
  end

  // Emit decision for the channel currently being scanned.
  always_comb begin
    dist_s   = abs_diff(shadow_q[idx_q], last_q[idx_q]);
    needed_s = 1'b0;
    if (first_q || (HYST == 0)) begin
      needed_s = 1'b1;
    end else begin
      needed_s = (32'(dist_s) >= HYST_U);
    end
  end

  // Delivery FSM next state, offered result and sticky overrun flag.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    last_d      = last_q;
    first_d     = first_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;

    // A new frame landing while delivery is still running is an overrun;
    // setting takes priority over a simultaneous clear.
    if (frame_done_q && (state_q != ST_IDLE)) begin
      overrun_d = 1'b1;
    end else if (clear_overrun) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end

    case (state_q)
      ST_IDLE: begin
        out_valid_d = 1'b0;
        if (frame_done_q) begin
          state_d = ST_SCAN;
          idx_d   = {CHW{1'b0}};
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_SCAN: begin
        if (needed_s) begin
          // Snapshot the result so it stays stable while offered, even if a
          // new frame rewrites the shadow meanwhile.
          state_d     = ST_OFFER;
          out_valid_d = 1'b1;
          out_data_d  = shadow_q[idx_q];
          out_ch_d    = idx_q;
        end else if (last_idx_s) begin
          state_d = ST_IDLE;
          first_d = 1'b0;
        end else begin
          idx_d = idx_q + CHW'(1);
        end
      end

      ST_OFFER: begin
        if (out_ready) begin
          out_valid_d   = 1'b0;
          last_d[idx_q] = out_data_q;
          if (last_idx_s) begin
            state_d = ST_IDLE;
            first_d = 1'b0;
          end else begin
            state_d = ST_SCAN;
            idx_d   = idx_q + CHW'(1);
          end
        end else begin
          out_valid_d = 1'b1;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // All state registers; reset discards any partial frame and pending offer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q      <= {CHANNELS{1'b0}};
      sync2_q      <= {CHANNELS{1'b0}};
      presc_q      <= {PSW{1'b0}};
      frame_q      <= {FW{1'b0}};
      high_q       <= {(CHANNELS * WIDTH){1'b0}};
      shadow_q     <= {(CHANNELS * WIDTH){1'b0}};
      frame_done_q <= 1'b0;
      state_q      <= ST_IDLE;
      idx_q        <= {CHW{1'b0}};
      last_q       <= {(CHANNELS * WIDTH){1'b0}};
      first_q      <= 1'b1;
      out_valid_q  <= 1'b0;
      out_data_q   <= {WIDTH{1'b0}};
      out_ch_q     <= {CHW{1'b0}};
      overrun_q    <= 1'b0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      presc_q      <= presc_d;
      frame_q      <= frame_d;
      high_q       <= high_d;
      shadow_q     <= shadow_d;
      frame_done_q <= frame_done_d;
      state_q      <= state_d;
      idx_q        <= idx_d;
      last_q       <= last_d;
      first_q      <= first_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_ch_q     <= out_ch_d;
      overrun_q    <= overrun_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_ch     = out_ch_q;
  assign frame_done = frame_done_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_pwm_duty_meter.sv
// Bench for pwm_duty_meter: CHANNELS=2, MAX_VAL=99, PRESCALE=4 (400-cycle
// frames). Two instances share all inputs: dut (no deadband) and dut_h
// (deadband of 3). Expected transfers are queued per instance when a
// frame's stimulus is driven and compared as the instances deliver them.

module tb_pwm_duty_meter;

  localparam int FRAME = 400;

  typedef struct {
    int h0;   // high samples for channel 0 in this frame
    int h1;   // high samples for channel 1 in this frame
    int e0;   // expected channel 0 result
    int e1;   // expected channel 1 result
    bit hy0;  // deadband instance emits channel 0
    bit hy1;  // deadband instance emits channel 1
  } vec_t;

  typedef struct {
    int ch;
    int data;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] comp = 2'b00;
  logic       out_ready = 1'b1;
  logic       clear_overrun = 1'b0;

  logic [6:0] d0, d1;
  logic [0:0] c0, c1;
  logic       v0, v1, fd0, fd1, ov0, ov1;

  int   cyc;
  int   checks = 0;
  int   errors = 0;
  int   stall_until = 0;
  int   fd_cnt [2];
  logic pv [2];
  logic [6:0] pd [2];
  logic [0:0] pc [2];
  logic pr = 1'b1;
  exp_t q0 [$];
  exp_t q1 [$];
  vec_t tbl [6];

  pwm_duty_meter #(.CHANNELS(2), .WIDTH(7), .MAX_VAL(99), .PRESCALE(4), .HYST(0)) dut (
    .clk(clk), .reset(reset), .comp(comp),
    .out_data(d0), .out_ch(c0), .out_valid(v0), .out_ready(out_ready),
    .frame_done(fd0), .overrun(ov0), .clear_overrun(clear_overrun)
  );

  pwm_duty_meter #(.CHANNELS(2), .WIDTH(7), .MAX_VAL(99), .PRESCALE(4), .HYST(3)) dut_h (
    .clk(clk), .reset(reset), .comp(comp),
    .out_data(d1), .out_ch(c1), .out_valid(v1), .out_ready(out_ready),
    .frame_done(fd1), .overrun(ov1), .clear_overrun(clear_overrun)
  );

  always #5 clk = ~clk;

  // Rising edges since reset release.
  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic chk(input bit ok, input string name, input int act, input int exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_both(input int ch, input int data, input bit to_h);
    exp_t e;
    e.ch = ch;
    e.data = data;
    q0.push_back(e);
    if (to_h) q1.push_back(e);
  endtask

  // Per-instance output monitor: offer stability, scoreboard, frame timing.
  task automatic observe(input int w, input logic v, input logic [6:0] d,
                         input logic [0:0] c, input logic fd);
    exp_t e;
    bit   have;
    if (pv[w] && !pr) begin
      chk(v == 1'b1, $sformatf("dut%0d_hold_valid", w), int'(v), 1);
      chk(d == pd[w], $sformatf("dut%0d_hold_data", w), int'(d), int'(pd[w]));
      chk(c == pc[w], $sformatf("dut%0d_hold_ch", w), int'(c), int'(pc[w]));
    end
    if (v && out_ready) begin
      have = 1'b0;
      if (w == 0) begin
        if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
      end else begin
        if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
      end
      if (!have) begin
        chk(1'b0, $sformatf("dut%0d_unexpected_xfer", w), int'(d), -1);
      end else begin
        chk(c == e.ch[0:0], $sformatf("dut%0d_xfer_ch", w), int'(c), e.ch);
        chk(int'(d) == e.data, $sformatf("dut%0d_xfer_data", w), int'(d), e.data);
      end
    end
    if (fd) begin
      chk((cyc % FRAME == 0) && (cyc > 0), $sformatf("dut%0d_frame_done_cycle", w),
          cyc, ((cyc + FRAME / 2) / FRAME) * FRAME);
      fd_cnt[w]++;
    end
    pv[w] = v;
    pd[w] = d;
    pc[w] = c;
  endtask

  initial begin
    fd_cnt[0] = 0; fd_cnt[1] = 0;
    pv[0] = 1'b0; pv[1] = 1'b0;
    pd[0] = 7'd0; pd[1] = 7'd0;
    pc[0] = 1'b0; pc[1] = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (reset) begin
        pv[0] = 1'b0;
        pv[1] = 1'b0;
      end else begin
        observe(0, v0, d0, c0, fd0);
        observe(1, v1, d1, c1, fd1);
      end
      pr = out_ready;
    end
  end

  // Assert reset at a falling edge, check outputs clear at once, release.
  task automatic do_reset(input int n);
    reset = 1'b1;
    #1;
    chk({v0, d0, c0, fd0, ov0} == 11'd0, "dut0_reset_outputs", int'({v0, d0, c0, fd0, ov0}), 0);
    chk({v1, d1, c1, fd1, ov1} == 11'd0, "dut1_reset_outputs", int'({v1, d1, c1, fd1, ov1}), 0);
    repeat (n) @(negedge clk);
    reset = 1'b0;
  endtask

  // Drive n cycles of a frame-aligned pattern: channel i high for the first
  // 4*hi cycles, which yields hi high samples after the synchronizer.
  task automatic drive_cycles(input int h0, input int h1, input int n);
    for (int j = 0; j < n; j++) begin
      comp[0] = (j < 4 * h0);
      comp[1] = (j < 4 * h1);
      out_ready = (cyc >= stall_until);
      @(negedge clk);
    end
  endtask

  task automatic check_drained(input string tag);
    chk(q0.size() == 0, {"dut0_drained_", tag}, q0.size(), 0);
    chk(q1.size() == 0, {"dut1_drained_", tag}, q1.size(), 0);
  endtask

  initial begin
    tbl[0] = '{100,   0, 99,  0, 1'b1, 1'b1};
    tbl[1] = '{ 50,   0, 50,  0, 1'b1, 1'b0};
    tbl[2] = '{ 51,  30, 51, 30, 1'b0, 1'b1};
    tbl[3] = '{ 54,  31, 54, 31, 1'b1, 1'b0};
    tbl[4] = '{ 53,  33, 53, 33, 1'b0, 1'b1};
    tbl[5] = '{  0, 100,  0, 99, 1'b1, 1'b1};

    @(negedge clk);
    do_reset(2);

    // Table of consecutive frames with out_ready held high.
    for (int f = 0; f < 6; f++) begin
      push_both(0, tbl[f].e0, 1'b0);
      push_both(1, tbl[f].e1, 1'b0);
      if (tbl[f].hy0) begin exp_t e; e.ch = 0; e.data = tbl[f].e0; q1.push_back(e); end
      if (tbl[f].hy1) begin exp_t e; e.ch = 1; e.data = tbl[f].e1; q1.push_back(e); end
      drive_cycles(tbl[f].h0, tbl[f].h1, FRAME);
    end

    // Consumer stalls 10 cycles during an offer.
    push_both(0, 20, 1'b1);
    push_both(1, 40, 1'b1);
    drive_cycles(20, 40, FRAME);
    out_ready = 1'b0;
    for (int i = 0; i < 10 && !v0; i++) @(negedge clk);
    chk(v0 == 1'b1, "stall_offer_seen", int'(v0), 1);
    repeat (10) begin
      @(negedge clk);
      chk(v0 == 1'b1, "stall_valid_held", int'(v0), 1);
    end
    out_ready = 1'b1;
    repeat (12) @(negedge clk);
    check_drained("stall");

    // Overrun: consumer stalls across the second frame_done.
    do_reset(2);
    push_both(0, 10, 1'b1);
    push_both(1, 40, 1'b1);
    push_both(0, 30, 1'b1);
    push_both(1, 40, 1'b0);
    stall_until = 850;
    drive_cycles(10, 20, FRAME);
    drive_cycles(30, 40, FRAME);
    chk(ov0 == 1'b0, "dut0_overrun_before_frame2", int'(ov0), 0);
    chk(ov1 == 1'b0, "dut1_overrun_before_frame2", int'(ov1), 0);
    drive_cycles(30, 40, FRAME);
    chk(ov0 == 1'b1, "dut0_overrun_sticky", int'(ov0), 1);
    chk(ov1 == 1'b1, "dut1_overrun_sticky", int'(ov1), 1);
    stall_until = 0;
    clear_overrun = 1'b1;
    @(negedge clk);
    clear_overrun = 1'b0;
    chk(ov0 == 1'b0, "dut0_overrun_cleared", int'(ov0), 0);
    chk(ov1 == 1'b0, "dut1_overrun_cleared", int'(ov1), 0);
    repeat (10) @(negedge clk);
    check_drained("overrun");

    // Reset 250 cycles into a frame; next frame must be complete and fresh.
    do_reset(2);
    drive_cycles(60, 70, 250);
    do_reset(3);
    push_both(0, 5, 1'b1);
    push_both(1, 95, 1'b1);
    drive_cycles(5, 95, FRAME);
    repeat (10) @(negedge clk);
    check_drained("midreset");
    chk(fd_cnt[0] == 11, "dut0_frame_done_count", fd_cnt[0], 11);
    chk(fd_cnt[1] == 11, "dut1_frame_done_count", fd_cnt[1], 11);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: still running at time %0t, required to end before 500000", $time);
    $fatal(1, "timeout");
  end

endmodule
